// File: rtl/control_step_sequencer_pkg.sv
// Shared definitions for the control step sequencer: float width, FSM encoding and
// the default responder timeout.
`ifndef SINGLE
`define SINGLE 32
`endif

package control_step_sequencer_pkg;

  localparam int TIMEOUT_DEFAULT = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_COMMIT = 2'd3
  } seq_state_t;

  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/control_step_sequencer_if.sv
// Start/done handshake between the step sequencer (master) and the PI responder (slave).
interface control_step_sequencer_if #(
  parameter int W = `SINGLE
) ();
  logic         sta;
  logic [W-1:0] x;
  logic         done_sig;
  logic [W-1:0] y;

  modport master (output sta, x, input done_sig, y);
  modport slave  (input sta, x, output done_sig, y);
endinterface

// File: rtl/control_step_sequencer_step_watchdog.sv
// Wait-state cycle counter; expired flags the last allowed WAIT cycle.
module step_watchdog
  import control_step_sequencer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/control_step_sequencer.sv
// Per-step sequencer: launches the PI responder, waits for its result with a watchdog,
// captures it and issues the commit pulse.
//
//   state    | meaning
//   S_IDLE   | waiting for step_tick
//   S_LAUNCH | sta pulse out, watchdog cleared
//   S_WAIT   | waiting for done_sig, watchdog counting
//   S_COMMIT | result captured, commit pulse follows
module control_step_sequencer
  import control_step_sequencer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int W       = `SINGLE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      step_tick,
  input  logic [W-1:0]              x_in,
  input  logic                      err_clr,
  control_step_sequencer_if.master  pi,
  output logic                      control_valuation_sig,
  output logic [W-1:0]              y_out,
  output logic                      y_valid,
  output logic                      busy,
  output logic                      overrun_err,
  output logic                      timeout_err
);

  seq_state_t   state, state_nxt;
  logic         accept, capture, to_hit, overrun_set;
  logic         wd_clr, wd_en, wd_expired;
  logic         sta_q;
  logic [W-1:0] x_q;

  step_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    to_hit    = 1'b0;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (step_tick) begin
          accept    = 1'b1;
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wd_clr    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        wd_en = 1'b1;
        // a result arriving on the expiry cycle still commits normally
        if (pi.done_sig) begin
          capture   = 1'b1;
          state_nxt = S_COMMIT;
        end else if (wd_expired) begin
          to_hit    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign overrun_set = step_tick && (state != S_IDLE);

  // busy stays high through the commit-pulse cycle so the step looks contiguous
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sta_q                 <= 1'b0;
      x_q                   <= '0;
      y_out                 <= '0;
      y_valid               <= 1'b0;
      control_valuation_sig <= 1'b0;
      busy                  <= 1'b0;
      overrun_err           <= 1'b0;
      timeout_err           <= 1'b0;
    end else begin
      sta_q                 <= accept;
      y_valid               <= capture;
      control_valuation_sig <= (state == S_COMMIT);
      busy                  <= (state_nxt != S_IDLE) || (state == S_COMMIT);
      overrun_err           <= overrun_set || (overrun_err && !err_clr);
      timeout_err           <= to_hit || (timeout_err && !err_clr);
      if (accept)  x_q   <= x_in;
      if (capture) y_out <= pi.y;
    end
  end

  assign pi.sta = sta_q;
  assign pi.x   = x_q;

endmodule

// File: tb/tb_control_step_sequencer.sv
// Bench for control_step_sequencer: step-level timing model plus a PI responder with
// configurable latency, driven by a scenario table, corner sequences and random traffic.
module tb_control_step_sequencer;

  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step_tick = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] x_in = '0;
  logic        control_valuation_sig, y_valid, busy, overrun_err, timeout_err;
  logic [31:0] y_out;

  control_step_sequencer_if #(.W(32)) bus ();

  control_step_sequencer #(.TIMEOUT(TO), .W(32)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .step_tick             (step_tick),
    .x_in                  (x_in),
    .err_clr               (err_clr),
    .pi                    (bus),
    .control_valuation_sig (control_valuation_sig),
    .y_out                 (y_out),
    .y_valid               (y_valid),
    .busy                  (busy),
    .overrun_err           (overrun_err),
    .timeout_err           (timeout_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit vec_bad;
  int cyc = 0;

  // step model: one accepted step described by its start cycle and responder latency
  bit          m_active = 0;
  int          m_start = 0, m_d = 0, m_accept_from = 0;
  logic [31:0] m_x = '0, m_yout = '0;
  bit          m_ov = 0, m_to = 0;
  int          cur_d = 19;

  bit          r_pend = 0;
  int          r_cycle = 0;
  logic [31:0] r_y = '0;

  int n_sta, n_yv, n_cvs;

  task automatic check_sig(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      vec_bad = 1'b1;
    end
  endtask

  task automatic run_cycle(input bit tick, input logic [31:0] xi, input bit clr,
                           input bit sp_done, input logic [31:0] sp_y);
    bit ok, e_sta, e_yv, e_cvs, e_busy, in_wait, idle, dn, ov_set, to_set;
    logic [31:0] yb;
    int k, last_busy;
    @(negedge clk);
    k = cyc;
    ok = (m_d >= 1) && (m_d <= TO);
    last_busy = ok ? m_start + m_d + 3 : m_start + TO + 1;
    e_sta  = m_active && (k == m_start + 1);
    e_yv   = m_active && ok && (k == m_start + m_d + 2);
    e_cvs  = m_active && ok && (k == m_start + m_d + 3);
    e_busy = m_active && (k >= m_start + 1) && (k <= last_busy);
    vec_bad = 1'b0;
    check_sig("sta", 32'(bus.sta), 32'(e_sta));
    check_sig("x", bus.x, m_x);
    check_sig("y_valid", 32'(y_valid), 32'(e_yv));
    check_sig("commit", 32'(control_valuation_sig), 32'(e_cvs));
    check_sig("y_out", y_out, m_yout);
    check_sig("busy", 32'(busy), 32'(e_busy));
    check_sig("overrun_err", 32'(overrun_err), 32'(m_ov));
    check_sig("timeout_err", 32'(timeout_err), 32'(m_to));
    vectors++;
    if (vec_bad) miscompares++;
    if (bus.sta) n_sta++;
    if (y_valid) n_yv++;
    if (control_valuation_sig) n_cvs++;

    // PI responder: answers D cycles after it sees sta, never when D exceeds the timeout
    if (bus.sta && m_active && (m_d <= TO)) begin
      r_pend  = 1'b1;
      r_cycle = k + m_d;
      r_y     = $urandom;
    end
    in_wait = m_active && (k >= m_start + 2) && (k <= (ok ? m_start + m_d + 1 : m_start + TO + 1));
    dn = sp_done && !in_wait;
    yb = sp_y;
    if (r_pend && (k == r_cycle)) begin
      dn = 1'b1;
      yb = r_y;
      r_pend = 1'b0;
    end
    step_tick    = tick;
    x_in         = xi;
    err_clr      = clr;
    bus.done_sig = dn;
    bus.y        = yb;

    idle   = !m_active || (k >= m_accept_from);
    ov_set = tick && !idle;
    to_set = m_active && !ok && (k == m_start + TO + 1);
    if (m_active && ok && (k == m_start + m_d + 1)) m_yout = yb;
    m_ov = ov_set || (m_ov && !clr);
    m_to = to_set || (m_to && !clr);
    if (tick && idle) begin
      m_active      = 1'b1;
      m_start       = k;
      m_d           = cur_d;
      m_x           = xi;
      m_accept_from = k + (((cur_d >= 1) && (cur_d <= TO)) ? cur_d + 3 : TO + 2);
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    step_tick = 1'b0;
    err_clr = 1'b0;
    bus.done_sig = 1'b0;
    #1;
    vec_bad = 1'b0;
    check_sig("rst_sta", 32'(bus.sta), 32'd0);
    check_sig("rst_x", bus.x, 32'd0);
    check_sig("rst_y_valid", 32'(y_valid), 32'd0);
    check_sig("rst_commit", 32'(control_valuation_sig), 32'd0);
    check_sig("rst_y_out", y_out, 32'd0);
    check_sig("rst_busy", 32'(busy), 32'd0);
    check_sig("rst_overrun", 32'(overrun_err), 32'd0);
    check_sig("rst_timeout", 32'(timeout_err), 32'd0);
    vectors++;
    if (vec_bad) miscompares++;
    m_active = 1'b0;
    m_x = '0;
    m_yout = '0;
    m_ov = 1'b0;
    m_to = 1'b0;
    r_pend = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, $urandom, 1'b0, 1'b0, 32'd0);
  endtask

  typedef struct {
    int          d;
    logic [31:0] xin;
    int          t2;
    int          e_sta;
    int          e_yv;
    int          e_cvs;
    bit          e_ov;
    bit          e_to;
  } row_t;

  row_t rows[8];

  initial begin
    logic [31:0] yo;
    bus.done_sig = 1'b0;
    bus.y = '0;

    rows[0] = '{19,     32'h40000000, 0,  1, 1, 1, 1'b0, 1'b0};
    rows[1] = '{19,     32'h3F800000, 10, 1, 1, 1, 1'b1, 1'b0};
    rows[2] = '{TO + 1, 32'hC0490FDB, 0,  1, 0, 0, 1'b0, 1'b1};
    rows[3] = '{TO,     32'h7F7FFFFF, 0,  1, 1, 1, 1'b0, 1'b0};
    rows[4] = '{1,      32'h00000001, 0,  1, 1, 1, 1'b0, 1'b0};
    rows[5] = '{5,      32'h80000000, 7,  1, 1, 1, 1'b1, 1'b0};
    rows[6] = '{5,      32'h7FC00000, 8,  2, 2, 2, 1'b0, 1'b0};
    rows[7] = '{TO - 1, 32'hFF800000, 0,  1, 1, 1, 1'b0, 1'b0};

    apply_reset();
    idle_cycles(3);

    for (int r = 0; r < 8; r++) begin
      n_sta = 0; n_yv = 0; n_cvs = 0;
      cur_d = rows[r].d;
      for (int i = 0; i < TO + 6; i++) begin
        run_cycle((i == 0) || ((rows[r].t2 > 0) && (i == rows[r].t2)),
                  ((i == 0) || (i == rows[r].t2)) ? rows[r].xin : $urandom,
                  1'b0, 1'b0, 32'd0);
      end
      #1;
      vec_bad = 1'b0;
      check_sig($sformatf("row%0d_sta_count", r), 32'(n_sta), 32'(rows[r].e_sta));
      check_sig($sformatf("row%0d_y_valid_count", r), 32'(n_yv), 32'(rows[r].e_yv));
      check_sig($sformatf("row%0d_commit_count", r), 32'(n_cvs), 32'(rows[r].e_cvs));
      check_sig($sformatf("row%0d_overrun", r), 32'(overrun_err), 32'(rows[r].e_ov));
      check_sig($sformatf("row%0d_timeout", r), 32'(timeout_err), 32'(rows[r].e_to));
      check_sig($sformatf("row%0d_x", r), bus.x, rows[r].xin);
      vectors++;
      if (vec_bad) miscompares++;
      run_cycle(1'b0, $urandom, 1'b1, 1'b0, 32'd0);
      idle_cycles(2);
    end

    // spurious done in IDLE must leave y_out alone
    yo = y_out;
    n_yv = 0;
    run_cycle(1'b0, $urandom, 1'b0, 1'b1, 32'hDEADBEEF);
    idle_cycles(3);
    #1;
    vec_bad = 1'b0;
    check_sig("spurious_y_out", y_out, yo);
    check_sig("spurious_y_valid_count", 32'(n_yv), 32'd0);
    vectors++;
    if (vec_bad) miscompares++;

    // reset in the middle of WAIT, then a clean step
    cur_d = 19;
    n_cvs = 0;
    for (int i = 0; i < 10; i++) run_cycle(i == 0, 32'h40000000, 1'b0, 1'b0, 32'd0);
    apply_reset();
    idle_cycles(3);
    #1;
    vec_bad = 1'b0;
    check_sig("abort_commit_count", 32'(n_cvs), 32'd0);
    vectors++;
    if (vec_bad) miscompares++;
    for (int i = 0; i < 24; i++) run_cycle(i == 0, 32'h41200000, 1'b0, 1'b0, 32'd0);

    // overrun set and err_clr in the same cycle: the set wins
    cur_d = 10;
    for (int i = 0; i < 16; i++)
      run_cycle((i == 0) || (i == 3), $urandom, (i == 3) || (i == 6), 1'b0, 32'd0);

    for (int i = 0; i < 4000; i++) begin
      bit t;
      t = ($urandom_range(0, 11) == 0);
      if (t) cur_d = $urandom_range(1, TO + 3);
      run_cycle(t, $urandom, $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_step_sequencer.md
CONTROL_STEP_SEQUENCER -- requirements
Module: control_step_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 32, is the maximum number of WAIT-state cycles allowed before done_sig must arrive.
REQ-002 Parameter W, default `SINGLE (32), is the IEEE-754 single data width.
REQ-003 clk  input  1  sole clock; all logic is rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 step_tick  input  1  simulation time-step strobe, one cycle wide.
REQ-006 x_in  input  W  controller error sample for this step.
REQ-007 err_clr  input  1  synchronous clear of the sticky error flags.
REQ-008 done_sig  input  1  completion strobe from the PI responder.
REQ-009 y  input  W  PI result; valid in the cycle done_sig is high.
REQ-010 sta  output  1  start pulse to the PI responder.
REQ-011 x  output  W  operand to the PI responder, held stable for the whole step.
REQ-012 control_valuation_sig  output  1  one-cycle commit pulse to the PI state storage.
REQ-013 y_out  output  W  captured PI result.
REQ-014 y_valid  output  1  one-cycle strobe; y_out is new.
REQ-015 busy  output  1  high in every state other than IDLE.
REQ-016 overrun_err  output  1  sticky flag; step_tick arrived while busy.
REQ-017 timeout_err  output  1  sticky flag; done_sig missing after TIMEOUT cycles.

Function
REQ-018 The FSM SHALL have the states IDLE, LAUNCH, WAIT and COMMIT, and all outputs SHALL be registered.
REQ-019 IDLE with step_tick=1 at edge T: x<=x_in and state<=LAUNCH; sta SHALL be high for exactly cycle T+1.
REQ-020 LAUNCH SHALL always go to WAIT on the next edge and clear the wait counter to 0.
REQ-021 WAIT SHALL increment the wait counter once per cycle, which saturates at TIMEOUT.
REQ-022 WAIT with done_sig=1: y_out<=y, y_valid=1 for one cycle, state<=COMMIT.
REQ-023 COMMIT SHALL drive control_valuation_sig=1 for exactly one cycle and then go to IDLE.
REQ-024 With a PI latency of D cycles (sta to done_sig), y_valid SHALL rise at T+D+2 and control_valuation_sig at T+D+3.
REQ-025 WAIT with the counter at TIMEOUT-1 and done_sig=0: timeout_err<=1 and state<=IDLE, with no y_valid and no commit pulse.
REQ-026 done_sig outside WAIT SHALL be ignored and SHALL produce no strobe.
REQ-027 done_sig and timeout in the same cycle: done_sig SHALL win (normal commit) and timeout_err SHALL NOT be set.
REQ-028 step_tick while busy SHALL be dropped and SHALL set overrun_err; the current step SHALL continue unaffected.
REQ-029 step_tick in the COMMIT cycle counts as overrun; the next accepted step_tick is the first one seen in IDLE.
REQ-030 err_clr=1 SHALL clear both flags; if a flag sets in the same cycle, the set SHALL win.
REQ-031 x SHALL change only on accepted step_tick; y_out SHALL change only on accepted done_sig.
REQ-032 The block SHALL NOT interpret or perform arithmetic on float data; values pass through bit-exact.

Reset
REQ-033 rst=1 SHALL force IDLE asynchronously and clear sta, control_valuation_sig, y_valid, busy, overrun_err, timeout_err, x, y_out and the counter to 0.
REQ-034 rst mid-step SHALL abort without a commit pulse; after rst falls, the first step_tick SHALL start a clean step.

Structure
REQ-035 The state encoding and the default TIMEOUT SHALL be defined in the shared global parameter include alongside `SINGLE.
REQ-036 The wait counter and its saturation/timeout compare SHALL be one sub-module, step_watchdog (inputs clr, en; output expired).

Verification
REQ-037 Nominal: PI model D=19, x_in=32'h40000000, step_tick at cycle 10 -> sta at 11, done at 30, y_out=model y with y_valid at 31, control_valuation_sig at 32, busy low at 33.
REQ-038 Timeout: TIMEOUT=32, done never arrives -> timeout_err=1 after 32 WAIT cycles, no y_valid, no commit, FSM back in IDLE; err_clr then clears the flag.
REQ-039 Overrun: step_tick at cycles 10 and 20 with D=19 -> overrun_err=1, exactly one sta pulse, and x still holds the cycle-10 sample.
REQ-040 Race: done_sig in the same cycle the counter expires -> normal commit and timeout_err=0.
REQ-041 Reset mid-WAIT at cycle 20 -> all outputs 0 immediately, no commit pulse; step_tick at cycle 25 -> sta at 26.
REQ-042 Spurious: done_sig pulsed in IDLE with y=32'hDEADBEEF -> y_out unchanged and y_valid=0.
